// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with one 7-bit address, byte receive/transmit handshakes and open-drain SDA control
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h6B
) (
    input  logic       i2c_core_clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK} state_t;
    state_t      state_q, state_d;
    logic [1:0]  scl_sync_q, sda_sync_q;
    logic        scl_prev_q, sda_prev_q;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        done_q, done_d;
    logic        sda_out_q, sda_out_d;
    logic        busy_q, busy_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_load_q, tx_load_d;
    logic        rw_q, rw_d;
    logic        ack_q, ack_d;
    logic        scl, sda, scl_rise, scl_fall, start, stop;
    assign scl      = scl_sync_q[1];
    assign sda      = sda_sync_q[1];
    assign scl_rise = scl & ~scl_prev_q;
    assign scl_fall = ~scl & scl_prev_q;
    assign start    = scl & scl_prev_q & sda_prev_q & ~sda;
    assign stop     = scl & scl_prev_q & ~sda_prev_q & sda;
    assign sda_out  = sda_out_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_load  = tx_load_q;
    assign busy     = busy_q;
    // Synchronize the bus lines and keep one-cycle-old copies for edge detection
    always_ff @(posedge i2c_core_clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_prev_q <= scl;
            sda_prev_q <= sda;
        end
    end
    // Protocol state and datapath registers
    always_ff @(posedge i2c_core_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd7;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            done_q     <= 1'b0;
            sda_out_q  <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            done_q     <= done_d;
            sda_out_q  <= sda_out_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
        end
    end
    // Next-state logic: STOP/START win over SCL edges; SDA only moves on SCL falls
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        done_d     = done_q;
        sda_out_d  = sda_out_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;
        rw_d       = rw_q;
        ack_d      = ack_q;
        if (stop) begin
            state_d   = IDLE;
            cnt_d     = 3'd7;
            done_d    = 1'b0;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
        end else if (start) begin
            state_d   = ADDR;
            cnt_d     = 3'd7;
            done_d    = 1'b0;
            sda_out_d = 1'b1;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise && !done_q) begin
                        shift_d = {shift_q[6:0], sda};
                        cnt_d   = cnt_q - 3'd1;
                        done_d  = cnt_q == 3'd0;
                    end else if (scl_fall && done_q) begin
                        done_d    = 1'b0;
                        rw_d      = shift_q[0];
                        state_d   = shift_q[7:1] == SLAVE_ADDR ? ADDR_ACK : IDLE;
                        sda_out_d = shift_q[7:1] != SLAVE_ADDR;
                        busy_d    = busy_q | (shift_q[7:1] == SLAVE_ADDR);
                    end
                end
                ADDR_ACK, TX_ACK: begin
                    if (state_q == TX_ACK && scl_rise && sda) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else if (scl_fall && (state_q == TX_ACK || rw_q)) begin
                        state_d   = TX_BYTE;
                        cnt_d     = 3'd7;
                        shift_d   = tx_data;
                        tx_load_d = 1'b1;
                        sda_out_d = tx_data[7];
                    end else if (scl_fall) begin
                        state_d   = RX_BYTE;
                        cnt_d     = 3'd7;
                        sda_out_d = 1'b1;
                    end
                end
                RX_BYTE: begin
                    if (scl_rise && !done_q) begin
                        shift_d = {shift_q[6:0], sda};
                        cnt_d   = cnt_q - 3'd1;
                        done_d  = cnt_q == 3'd0;
                        if (cnt_q == 3'd0) begin
                            ack_d      = rx_ready;
                            rx_data_d  = rx_ready ? {shift_q[6:0], sda} : rx_data_q;
                            rx_valid_d = rx_ready;
                        end
                    end else if (scl_fall && done_q) begin
                        done_d    = 1'b0;
                        state_d   = ack_q ? RX_ACK : IDLE;
                        sda_out_d = !ack_q;
                        busy_d    = ack_q;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        state_d   = RX_BYTE;
                        sda_out_d = 1'b1;
                    end
                end
                TX_BYTE: begin
                    if (scl_fall) begin
                        cnt_d     = cnt_q - 3'd1;
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_out_d = cnt_q == 3'd0 ? 1'b1 : shift_q[6];
                        state_d   = cnt_q == 3'd0 ? TX_ACK : TX_BYTE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h6B, the 7-bit address this target responds to.
REQ-002 SHALL have port i2c_core_clk  input  1  the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port scl_in  input  1  bus SCL level, asynchronous to i2c_core_clk.
REQ-005 SHALL have port sda_in  input  1  bus SDA level, asynchronous to i2c_core_clk.
REQ-006 SHALL have port sda_out  output  1  open-drain control: 0 pulls SDA low, 1 releases it.
REQ-007 SHALL have port rx_data  output  8  last byte received from the master.
REQ-008 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-009 SHALL have port rx_ready  input  1  user can accept a byte; when low, the received byte is NACKed.
REQ-010 SHALL have port tx_data  input  8  byte to transmit, sampled at load points.
REQ-011 SHALL have port tx_load  output  1  one-cycle pulse when tx_data is sampled.
REQ-012 SHALL have port busy  output  1  high from an address match until STOP or release.

Function
REQ-013 SHALL pass scl_in and sda_in through 2-flop synchronizers; all edge and level decisions use the synchronized values and their 1-cycle-delayed copies.
REQ-014 SHALL require i2c_core_clk to be at least 8x the SCL frequency; behaviour below that is undefined.
REQ-015 SHALL detect START as synchronized SDA 1->0 while SCL is 1, and STOP as SDA 0->1 while SCL is 1.
REQ-016 SHALL implement states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK.
REQ-017 SHALL enter ADDR on START from any state, including a repeated START; the bit counter is set to 7.
REQ-018 SHALL enter IDLE on STOP from any state, release sda_out and clear busy in the same cycle.
REQ-019 SHALL sample SDA MSB-first on each detected SCL rising edge in ADDR, RX_BYTE and TX_ACK.
REQ-020 SHALL change sda_out only on detected SCL falling edges, except on STOP and reset.
REQ-021 After 8 address bits: if bits[7:1] == SLAVE_ADDR, SHALL drive sda_out 0 at the next SCL falling edge, set busy and enter ADDR_ACK; otherwise SHALL return to IDLE with sda_out released.
REQ-022 SHALL release SDA at the SCL falling edge that ends ADDR_ACK, then enter RX_BYTE if R/W = 0 or TX_BYTE if R/W = 1.
REQ-023 For R/W = 1, SHALL sample tx_data and pulse tx_load at that same falling edge; tx_data bit 7 SHALL be driven on sda_out in that edge.
REQ-024 In RX_BYTE, on the SCL rising edge of bit 0 SHALL update rx_data and pulse rx_valid 1 cycle later, but only if rx_ready = 1.
REQ-025 In RX_ACK, SHALL drive ACK (0) during the ninth clock if rx_ready was 1 at bit 0, then return to RX_BYTE.
REQ-026 If rx_ready was 0 at bit 0, SHALL NACK (release SDA), emit no rx_valid, and go to IDLE.
REQ-027 In TX_BYTE, SHALL shift bits 6..0 out on successive SCL falling edges, then release SDA for the master ACK.
REQ-028 In TX_ACK, on the SCL rising edge: if SDA = 0, SHALL load tx_data and pulse tx_load at the next falling edge and re-enter TX_BYTE; if SDA = 1, SHALL release SDA and go to IDLE.
REQ-029 The bit counter SHALL wrap 0->7 at every byte boundary with no overflow into the ACK state.
REQ-030 SHALL give START and STOP priority over a simultaneous SCL edge in the same cycle.

Reset
REQ-031 While rst = 1, SHALL hold state IDLE, sda_out = 1, rx_data = 8'h00, rx_valid = 0, tx_load = 0, busy = 0, counter = 7, and synchronizers at 1.
REQ-032 Reset asserted mid-transfer SHALL release SDA immediately; after deassertion the block SHALL ignore the bus until the next START.

Verification
REQ-033 START, address 0xD6 (0x6B, write), byte 0xA5, rx_ready = 1, STOP -> ACK on both 9th clocks, rx_data = 0xA5, one rx_valid pulse, busy falls at STOP.
REQ-034 START, address 0xD7, tx_data = 0x3C, then 0x81, master ACKs then NACKs -> SDA carries 0x3C then 0x81, two tx_load pulses, SDA released after the NACK.
REQ-035 START, address 0x54 -> no ACK, sda_out = 1 throughout, busy = 0, no rx_valid.
REQ-036 Write 0x11 with rx_ready = 0 -> NACK on the 9th clock, no rx_valid, state IDLE.
REQ-037 Write, then repeated START, then read -> re-enters ADDR, ACKs again, tx_load pulses.
REQ-038 rst pulsed while the slave drives 0 during bit 3 of TX -> sda_out = 1 asynchronously, all outputs at reset values, next START handled normally.
